edge_router_sync_ctrl: RTL and testbench
========================================

// Module: edge_router_sync_ctrl
// PURPOSE
//  Avalon-MM controlled select for the edge-detection stream router. Software writes a
//  requested route. The block applies it to route_sel only at a video packet boundary,
//  found by snooping the Avalon-ST handshake, so no frame is split across paths.
//  A programmable timeout forces the switch if the stream stalls mid-packet.
//  Sits between the HPS/Nios bus and the router's select input.
// PARAMETERS
//  TIMEOUT_DEFAULT  16'd0    reset value of TIMEOUT reg; 0 = never force
//  CNT_W            16       width of timeout counter and frame counter
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  address      in   2   register word address
//  chipselect   in   1   slave select
//  write_n      in   1   active-low write strobe
//  writedata    in   32  write data
//  readdata     out  32  read data, combinational, 0 wait/latency
//  st_valid     in   1   snooped router-input valid
//  st_ready     in   1   snooped router-input ready
//  st_sop       in   1   snooped startofpacket
//  st_eop       in   1   snooped endofpacket
//  route_sel    out  1   router select (registered)
//  pending      out  1   switch requested, not yet applied
// BEHAVIOUR
//  Reset values: route_sel=0, pending=0, req_sel=0, in_pkt=0, forced=0, frame_cnt=0,
//   timeout=TIMEOUT_DEFAULT, tcnt=0, state=IDLE.
//  Definitions: beat = st_valid & st_ready. wr = chipselect & ~write_n.
//  in_pkt: set on beat&st_sop&~st_eop; clear on beat&st_eop (sop+eop same beat -> stays 0).
//  frame_cnt: +1 on beat&st_eop; wraps at 2^CNT_W; a write to addr2 clears it (write wins).
//  Register map (reads of unlisted bits = 0):
//   0 CTRL    RW [0] req_sel
//   1 STATUS  R  [0] route_sel [1] pending [2] in_pkt [3] forced; W1C [3]
//   2 FRMCNT  R  [CNT_W-1:0] frame_cnt; any write clears
//   3 TIMEOUT RW [CNT_W-1:0] timeout, in cycles
//  FSM:
//   IDLE: if req_sel!=route_sel -> PENDING, tcnt<=0.
//   PENDING:
//    - Commit when in_pkt==0 and no beat this cycle: route_sel<=req_sel -> IDLE.
//    - Else if timeout!=0 and tcnt==timeout-1: force commit, forced<=1 -> IDLE.
//    - Else tcnt<=tcnt+1, saturating.
//    - If req_sel==route_sel (request rewritten back), go to IDLE without a commit.
//  pending = (state==PENDING); registered, so it rises the cycle after the request differs.
//  Latency: idle stream, write req at edge N -> pending at N+1, route_sel at N+2.
//  Simultaneous CTRL write and commit: the commit uses the pre-write req_sel. The new
//   value is evaluated from the next cycle; no lost or spurious switch.
//  Forced commit mid-packet: in_pkt is not altered; tracking resumes from the snooped eop.
//  Writing TIMEOUT while PENDING: takes effect immediately; tcnt is not reset.
//  Async reset mid-packet or mid-PENDING returns all state to reset values.
// STRUCTURE
//  Shared pkg: register address localparams (CTRL/STATUS/FRMCNT/TIMEOUT), STATUS bit
//   indices, FSM state encoding typedef.
//  One sub-module is natural: edge_pkt_tracker (in_pkt + frame_cnt from the snoop inputs).
//  The FSM, timeout counter and register file stay in the top module.
// TESTING
//  1 Idle stream, write CTRL=1 -> pending=1 next cycle, route_sel=1 the cycle after,
//    STATUS reads 0x1.
//  2 Packet of 100 beats in flight, write CTRL=1 at beat 10 -> route_sel stays 0 until
//    the first cycle after the eop beat with no beat; frame_cnt=1.
//  3 TIMEOUT=50, stream stalls mid-packet, write CTRL=1 -> route_sel=1 exactly 50 cycles
//    after pending rises; STATUS[3]=1; write STATUS 0x8 -> STATUS[3]=0.
//  4 In-flight packet, write CTRL=1 then CTRL=0 before eop -> pending returns to 0,
//    route_sel never toggles.
//  5 sop+eop single-beat packets every cycle, then one gap cycle -> commit lands only in
//    the gap cycle; frame_cnt counts every beat; 0xFFFF+1 wraps to 0.
//  6 Assert reset_n=0 mid-packet with pending=1 -> all outputs and readdata fields read
//    reset values immediately.

Source files
------------

// File: rtl/edge_router_sync_ctrl_pkg.sv
// Shared definitions for the edge-router select controller: register map,
// STATUS bit positions and FSM state encoding.
package edge_router_sync_ctrl_pkg;

  localparam logic [1:0] AddrCtrl    = 2'd0;
  localparam logic [1:0] AddrStatus  = 2'd1;
  localparam logic [1:0] AddrFrmcnt  = 2'd2;
  localparam logic [1:0] AddrTimeout = 2'd3;

  localparam int unsigned StatRoute   = 0;
  localparam int unsigned StatPending = 1;
  localparam int unsigned StatInPkt   = 2;
  localparam int unsigned StatForced  = 3;

  typedef enum logic {
    StIdle,
    StPending
  } state_e;

endpackage

// File: rtl/edge_router_sync_ctrl_edge_pkt_tracker.sv
// Tracks packet framing on the snooped Avalon-ST handshake: in-packet flag and
// a wrapping count of completed frames.
module edge_router_sync_ctrl_edge_pkt_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             st_valid,
  input  logic             st_ready,
  input  logic             st_sop,
  input  logic             st_eop,
  input  logic             frame_clr,
  output logic             beat,
  output logic             in_pkt,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign beat = st_valid & st_ready;

  always_comb begin
    in_pkt_d    = in_pkt_q;
    frame_cnt_d = frame_cnt_q;
    // A single-beat packet (sop and eop together) never enters the packet.
    if (beat && st_eop) begin
      in_pkt_d = 1'b0;
    end else if (beat && st_sop) begin
      in_pkt_d = 1'b1;
    end
    if (frame_clr) begin
      frame_cnt_d = '0;
    end else if (beat && st_eop) begin
      frame_cnt_d = frame_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_pkt    = in_pkt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: rtl/edge_router_sync_ctrl.sv
// Avalon-MM controlled route select that only switches the edge-detection router
// between packets, with an optional stall timeout that forces the switch.
module edge_router_sync_ctrl
  import edge_router_sync_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_DEFAULT = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        st_valid,
  input  logic        st_ready,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        route_sel,
  output logic        pending
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             wr, wr_ctrl, wr_status, wr_frmcnt, wr_timeout;
  logic             beat, in_pkt;
  logic [CNT_W-1:0] frame_cnt;

  state_e           state_q, state_d;
  logic             route_sel_q, route_sel_d;
  logic             req_sel_q, forced_q, force_set;
  logic [CNT_W-1:0] timeout_q, tcnt_q, tcnt_d;

  logic             unused_wdata;
  assign unused_wdata = ^writedata[31:CNT_W];

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr & (address == AddrCtrl);
  assign wr_status  = wr & (address == AddrStatus);
  assign wr_frmcnt  = wr & (address == AddrFrmcnt);
  assign wr_timeout = wr & (address == AddrTimeout);

  edge_router_sync_ctrl_edge_pkt_tracker #(
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_sop    (st_sop),
    .st_eop    (st_eop),
    .frame_clr (wr_frmcnt),
    .beat      (beat),
    .in_pkt    (in_pkt),
    .frame_cnt (frame_cnt)
  );

  // Commit decisions use the registered req_sel, so a CTRL write landing on the
  // commit cycle is only seen from the following cycle.
  always_comb begin
    state_d     = state_q;
    route_sel_d = route_sel_q;
    tcnt_d      = tcnt_q;
    force_set   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_sel_q != route_sel_q) begin
          state_d = StPending;
          tcnt_d  = '0;
        end
      end
      StPending: begin
        if (req_sel_q == route_sel_q) begin
          state_d = StIdle;
        end else if (!in_pkt && !beat) begin
          route_sel_d = req_sel_q;
          state_d     = StIdle;
        end else if ((timeout_q != '0) && (tcnt_q == timeout_q - CntOne)) begin
          route_sel_d = req_sel_q;
          force_set   = 1'b1;
          state_d     = StIdle;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      route_sel_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      route_sel_q <= route_sel_d;
      tcnt_q      <= tcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sel_q <= 1'b0;
      forced_q  <= 1'b0;
      timeout_q <= TIMEOUT_DEFAULT;
    end else begin
      if (wr_ctrl) begin
        req_sel_q <= writedata[0];
      end
      // A force event in the same cycle as the clear keeps the flag visible.
      if (force_set) begin
        forced_q <= 1'b1;
      end else if (wr_status && writedata[StatForced]) begin
        forced_q <= 1'b0;
      end
      if (wr_timeout) begin
        timeout_q <= writedata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      AddrCtrl:    readdata[0] = req_sel_q;
      AddrStatus: begin
        readdata[StatRoute]   = route_sel_q;
        readdata[StatPending] = (state_q == StPending);
        readdata[StatInPkt]   = in_pkt;
        readdata[StatForced]  = forced_q;
      end
      AddrFrmcnt:  readdata[CNT_W-1:0] = frame_cnt;
      AddrTimeout: readdata[CNT_W-1:0] = timeout_q;
      default:     readdata = '0;
    endcase
  end

  assign route_sel = route_sel_q;
  assign pending   = (state_q == StPending);

endmodule

// File: tb/tb_edge_router_sync_ctrl.sv
// Self-checking bench for edge_router_sync_ctrl: directed scenarios plus random
// traffic, all compared each cycle against a behavioural model.
module tb_edge_router_sync_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        st_valid, st_ready, st_sop, st_eop;
  logic        route_sel, pending;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          check_en = 0;

  // Model state
  bit          m_route = 0, m_req = 0, m_pend = 0, m_inpkt = 0, m_forced = 0;
  int unsigned m_tcnt = 0, m_frames = 0, m_timeout = 0;

  edge_router_sync_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_sop     (st_sop),
    .st_eop     (st_eop),
    .route_sel  (route_sel),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_req};
      2'd1:    return {28'd0, m_forced, m_inpkt, m_pend, m_route};
      2'd2:    return m_frames;
      default: return m_timeout;
    endcase
  endfunction

  function automatic void model_reset();
    m_route = 0; m_req = 0; m_pend = 0; m_inpkt = 0; m_forced = 0;
    m_tcnt = 0; m_frames = 0; m_timeout = 0;
  endfunction

  // One clock of the specified behaviour, all decisions from pre-edge values.
  function automatic void model_step();
    bit beat, wr, n_route, n_pend, n_inpkt, n_forced, fset;
    int unsigned n_tcnt, n_frames;
    beat = st_valid && st_ready;
    wr   = chipselect && !write_n;
    n_inpkt = m_inpkt;
    if (beat && st_eop) n_inpkt = 0;
    else if (beat && st_sop) n_inpkt = 1;
    if (wr && address == 2'd2) n_frames = 0;
    else if (beat && st_eop) n_frames = (m_frames + 1) % 65536;
    else n_frames = m_frames;
    n_route = m_route; n_pend = m_pend; n_tcnt = m_tcnt; fset = 0;
    if (!m_pend) begin
      if (m_req != m_route) begin n_pend = 1; n_tcnt = 0; end
    end else if (m_req == m_route) begin
      n_pend = 0;
    end else if (!m_inpkt && !beat) begin
      n_route = m_req; n_pend = 0;
    end else if (m_timeout != 0 && m_tcnt == m_timeout - 1) begin
      n_route = m_req; n_pend = 0; fset = 1;
    end else if (m_tcnt < 65535) begin
      n_tcnt = m_tcnt + 1;
    end
    n_forced = m_forced;
    if (fset) n_forced = 1;
    else if (wr && address == 2'd1 && writedata[3]) n_forced = 0;
    if (wr && address == 2'd0) m_req = writedata[0];
    if (wr && address == 2'd3) m_timeout = writedata[15:0];
    m_route = n_route; m_pend = n_pend; m_tcnt = n_tcnt; m_inpkt = n_inpkt;
    m_frames = n_frames; m_forced = n_forced;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("route_sel", {31'd0, route_sel}, {31'd0, m_route});
      check("pending", {31'd0, pending}, {31'd0, m_pend});
      check("readdata", readdata, exp_rd(address));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    chipselect = 0; write_n = 1; address = 0; writedata = 0;
    st_valid = 0; st_ready = 1; st_sop = 0; st_eop = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  initial begin
    reset_n = 0;
    idle_inputs();
    do_reset();
    check_en = 1;

    // Reset state
    check("rst_route", {31'd0, route_sel}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);
    rd_check("rst_status", 2'd1, 32'h0);
    rd_check("rst_timeout", 2'd3, 32'h0);

    // 1: idle stream latency
    wr(2'd0, 32'd1);
    check("t1_pend_n1", {31'd0, pending}, 32'd0);
    tick();
    check("t1_pend", {31'd0, pending}, 32'd1);
    check("t1_route_early", {31'd0, route_sel}, 32'd0);
    tick();
    check("t1_route", {31'd0, route_sel}, 32'd1);
    rd_check("t1_status", 2'd1, 32'h1);

    // 2: 100-beat packet, request at beat 10
    do_reset();
    for (int i = 0; i < 100; i++) begin
      st_valid = 1; st_ready = 1; st_sop = (i == 0); st_eop = (i == 99);
      if (i == 10) begin
        chipselect = 1; write_n = 0; address = 2'd0; writedata = 32'd1;
      end else begin
        chipselect = 0; write_n = 1;
      end
      tick();
      check("t2_route_hold", {31'd0, route_sel}, 32'd0);
    end
    st_valid = 0; st_sop = 0; st_eop = 0;
    tick();
    check("t2_route", {31'd0, route_sel}, 32'd1);
    rd_check("t2_frmcnt", 2'd2, 32'd1);

    // 3: timeout forces the switch on a stalled packet
    do_reset();
    wr(2'd3, 32'd50);
    st_valid = 1; st_sop = 1;
    tick();
    st_valid = 0; st_sop = 0;
    wr(2'd0, 32'd1);
    tick();
    check("t3_pend", {31'd0, pending}, 32'd1);
    for (int i = 0; i < 49; i++) begin
      tick();
      check("t3_route_hold", {31'd0, route_sel}, 32'd0);
    end
    tick();
    check("t3_route", {31'd0, route_sel}, 32'd1);
    rd_check("t3_status", 2'd1, 32'hD);
    wr(2'd1, 32'h8);
    rd_check("t3_w1c", 2'd1, 32'h5);
    st_valid = 1; st_eop = 1;
    tick();
    st_valid = 0; st_eop = 0;
    rd_check("t3_inpkt_clr", 2'd1, 32'h1);

    // 4: request withdrawn before eop
    do_reset();
    for (int i = 0; i < 40; i++) begin
      st_valid = 1; st_sop = (i == 0); st_eop = (i == 39);
      chipselect = (i == 5 || i == 15); write_n = !(i == 5 || i == 15);
      address = 2'd0; writedata = (i == 5) ? 32'd1 : 32'd0;
      tick();
      check("t4_route", {31'd0, route_sel}, 32'd0);
      if (i == 8) check("t4_pend_up", {31'd0, pending}, 32'd1);
      if (i == 20) check("t4_pend_dn", {31'd0, pending}, 32'd0);
    end
    idle_inputs();
    repeat (3) tick();
    check("t4_route_end", {31'd0, route_sel}, 32'd0);

    // 5: back-to-back single-beat packets, commit only in the gap
    do_reset();
    st_valid = 1; st_sop = 1; st_eop = 1;
    wr(2'd0, 32'd1);
    for (int i = 0; i < 19; i++) begin
      tick();
      check("t5_route_hold", {31'd0, route_sel}, 32'd0);
    end
    st_valid = 0;
    tick();
    check("t5_route", {31'd0, route_sel}, 32'd1);
    rd_check("t5_frmcnt", 2'd2, 32'd20);
    wr(2'd2, 32'd0);
    rd_check("t5_frmclr", 2'd2, 32'd0);
    st_valid = 1;
    repeat (65535) tick();
    st_valid = 0;
    rd_check("t5_ffff", 2'd2, 32'hFFFF);
    st_valid = 1;
    tick();
    st_valid = 0;
    rd_check("t5_wrap", 2'd2, 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      st_valid = ($urandom_range(0, 3) != 0);
      st_ready = ($urandom_range(0, 3) != 0);
      st_sop   = ($urandom_range(0, 3) == 0);
      st_eop   = ($urandom_range(0, 4) == 0);
      address  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1; write_n = 0;
        writedata = (address == 2'd3) ? 32'($urandom_range(0, 12)) : $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1; writedata = $urandom;
      end
      tick();
    end

    // 6: async reset mid-packet while pending
    do_reset();
    wr(2'd3, 32'd100);
    st_valid = 1; st_sop = 1;
    tick();
    st_valid = 0; st_sop = 0;
    wr(2'd0, 32'd1);
    tick();
    check("t6_pend", {31'd0, pending}, 32'd1);
    #3 reset_n = 0;
    #1;
    check("t6_route", {31'd0, route_sel}, 32'd0);
    check("t6_pending", {31'd0, pending}, 32'd0);
    for (int a = 0; a < 4; a++) rd_check("t6_readdata", 2'(a), 32'd0);
    tick();
    reset_n = 1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
